// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update sequencer.
// Holds the controller states, the in-flight entry type and the default depth.
package bp_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } bp_state_t;

   // One in-flight branch; extra fields (e.g. target) get added here.
   typedef struct packed {
      logic taken;
   } bp_entry_t;

   localparam int BP_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predictions awaiting resolution.
// Ports: clk, reset, clear, push, pop, push_data, head, full, empty, occupancy.
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = BP_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  bp_entry_t                push_data,
   output bp_entry_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   bp_entry_t   mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   // Extra pointer bit separates full from empty when indices match.
   assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                      (wr_ptr[AW] != rd_ptr[AW]);
   assign empty     = (wr_ptr == rd_ptr);
   assign occupancy = wr_ptr - rd_ptr;
   assign head      = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/bp_update_ctrl.sv
// Sequences predictor updates and mispredict flushes for in-flight branches.
// Ports: clk, reset, pred_*, res_*, upd_*, flush, occupancy, err_underflow;
// stat_branches/stat_mispred exist only when BP_STATS_EN is defined.
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int DEPTH = BP_DEPTH_DEFAULT,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pred_valid,
   input  logic                     pred_taken,
   output logic                     pred_ready,
   input  logic                     res_valid,
   input  logic                     res_taken,
   output logic                     upd_branch,
   output logic                     upd_taken,
   output logic                     flush,
`ifdef BP_STATS_EN
   output logic [CNT_W-1:0]         stat_branches,
   output logic [CNT_W-1:0]         stat_mispred,
`endif
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     err_underflow
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two, at least 2");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("CNT_W must be at least 1");
   end

   bp_state_t state;
   bp_state_t state_next;
   bp_entry_t head;
   bp_entry_t push_data;
   logic      full;
   logic      empty;
   logic      pop;
   logic      push;
   logic      mispred;
   logic      underflow;

   bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (mispred),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .occupancy (occupancy)
   );

   assign push_data = '{taken: pred_taken};

   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         RUN:     if (mispred) state_next = RECOVER;
         RECOVER: state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // A mispredict clears the queue, so a same-cycle push is dropped.
   always_comb begin
      pred_ready = 1'b0;
      pop        = 1'b0;
      mispred    = 1'b0;
      push       = 1'b0;
      underflow  = 1'b0;
      if (state == RUN) begin
         pred_ready = !full;
         pop        = res_valid && !empty;
         mispred    = pop && (res_taken != head.taken);
         push       = pred_valid && !full && !mispred;
         underflow  = res_valid && empty;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         upd_branch    <= 1'b0;
         upd_taken     <= 1'b0;
         flush         <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         upd_branch <= pop;
         upd_taken  <= pop && res_taken;
         flush      <= mispred;
         if (underflow) err_underflow <= 1'b1;
      end
   end

`ifdef BP_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else begin
         if (pop && stat_branches != '1)
            stat_branches <= stat_branches + CNT_W'(1);
         if (mispred && stat_mispred != '1)
            stat_mispred <= stat_mispred + CNT_W'(1);
      end
   end
`endif

endmodule
